// File: rtl/traffic_light_fsm_pkg.sv
// rtl/traffic_light_fsm_pkg.sv - shared state and lamp encodings for the junction controller
package traffic_light_fsm_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5
  } state_e;

  // Lamp vectors are {red, yellow, green}
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  function automatic logic [2:0] main_lamp(input state_e s);
    case (s)
      MAIN_GREEN:  return GRN;
      MAIN_YELLOW: return YEL;
      default:     return RED;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input state_e s);
    case (s)
      SIDE_GREEN:  return GRN;
      SIDE_YELLOW: return YEL;
      default:     return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_fsm_timer.sv
// rtl/traffic_light_fsm_timer.sv - tick-gated phase timer with clear, saturate and expiry compare
module phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               tick_i,
  input  logic               clear_i,
  input  logic [TIMER_W-1:0] limit_i,
  output logic               expire_o
);

  logic [TIMER_W-1:0] timer_q, timer_d;

  // Clear on phase entry; otherwise count ticks, holding at the phase limit
  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (tick_i && (timer_q < limit_i)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Timer register
  always_ff @(posedge clk) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // The tick that lands on the last count of a phase ends it
  assign expire_o = tick_i && (timer_q == limit_i);

endmodule

// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - two-road junction phase controller with pedestrian walk lamp
module traffic_light_fsm
  import traffic_light_fsm_pkg::*;
#(
  parameter int MAIN_GREEN_S  = 10,
  parameter int MAIN_YELLOW_S = 3,
  parameter int ALL_RED_S     = 1,
  parameter int SIDE_GREEN_S  = 6,
  parameter int SIDE_YELLOW_S = 3,
  parameter int TIMER_W       = 8
) (
  input  logic       clk,
  input  logic       controller_reset,
  input  logic       sec_tick,
  input  logic       side_car,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [TIMER_W-1:0] MG_LIM = TIMER_W'(MAIN_GREEN_S - 1);
  localparam logic [TIMER_W-1:0] MY_LIM = TIMER_W'(MAIN_YELLOW_S - 1);
  localparam logic [TIMER_W-1:0] AR_LIM = TIMER_W'(ALL_RED_S - 1);
  localparam logic [TIMER_W-1:0] SG_LIM = TIMER_W'(SIDE_GREEN_S - 1);
  localparam logic [TIMER_W-1:0] SY_LIM = TIMER_W'(SIDE_YELLOW_S - 1);

  state_e             state_q, state_d;
  logic [2:0]         main_q, side_q;
  logic               walk_q, walk_d;
  logic               ped_pending_q, ped_pending_d;
  logic [TIMER_W-1:0] limit;
  logic               expire;
  logic               enter_side;

  // Last timer count of the current phase; main green holds here until demand
  always_comb begin
    limit = AR_LIM;
    case (state_q)
      MAIN_GREEN:  limit = MG_LIM;
      MAIN_YELLOW: limit = MY_LIM;
      SIDE_GREEN:  limit = SG_LIM;
      SIDE_YELLOW: limit = SY_LIM;
      default:     limit = AR_LIM;
    endcase
  end

  phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst_i    (controller_reset),
    .tick_i   (sec_tick),
    .clear_i  (state_d != state_q),
    .limit_i  (limit),
    .expire_o (expire)
  );

  // Next phase, pedestrian latch and walk lamp
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_GREEN:  if (expire && (side_car || ped_pending_q)) state_d = MAIN_YELLOW;
      MAIN_YELLOW: if (expire) state_d = ALL_RED_A;
      ALL_RED_A:   if (expire) state_d = SIDE_GREEN;
      SIDE_GREEN:  if (expire) state_d = SIDE_YELLOW;
      SIDE_YELLOW: if (expire) state_d = ALL_RED_B;
      ALL_RED_B:   if (expire) state_d = MAIN_GREEN;
      default:     state_d = ALL_RED_B;
    endcase
    enter_side    = (state_d == SIDE_GREEN) && (state_q != SIDE_GREEN);
    // A new press on the clearing edge survives into the next cycle
    ped_pending_d = ped_req || (ped_pending_q && !enter_side);
    walk_d        = (state_d == SIDE_GREEN) && (enter_side ? ped_pending_q : walk_q);
  end

  // State and registered lamp decode of the next state
  always_ff @(posedge clk) begin
    if (controller_reset) begin
      state_q       <= ALL_RED_B;
      main_q        <= RED;
      side_q        <= RED;
      walk_q        <= 1'b0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      main_q        <= main_lamp(state_d);
      side_q        <= side_lamp(state_d);
      walk_q        <= walk_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  assign main_light = main_q;
  assign side_light = side_q;
  assign walk       = walk_q;
  assign phase      = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb/tb_traffic_light_fsm.sv - self-checking bench for traffic_light_fsm
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       controller_reset, sec_tick, side_car, ped_req;
  logic [2:0] main_light, side_light, phase;
  logic       walk;

  int total = 0;
  int bad   = 0;
  int wt, sg, n;
  bit found;

  // Reference: phase index, ticks spent in phase, pending request, walk lamp
  int dur[6] = '{10, 3, 1, 6, 3, 1};
  int m_ph, m_el;
  bit m_pend, m_walk;

  always #5 clk = ~clk;

  traffic_light_fsm dut (
    .clk              (clk),
    .controller_reset (controller_reset),
    .sec_tick         (sec_tick),
    .side_car         (side_car),
    .ped_req          (ped_req),
    .main_light       (main_light),
    .side_light       (side_light),
    .walk             (walk),
    .phase            (phase)
  );

  function automatic logic [2:0] exp_main(input int ph);
    if (ph == 0) return 3'b001;
    if (ph == 1) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_side(input int ph);
    if (ph == 3) return 3'b001;
    if (ph == 4) return 3'b010;
    return 3'b100;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input bit t, input bit c, input bit p, input bit r);
    bit adv;
    int nph;
    sec_tick = t; side_car = c; ped_req = p; controller_reset = r;
    @(posedge clk);
    if (r) begin
      m_ph = 5; m_el = 0; m_pend = 0; m_walk = 0;
    end else begin
      adv = t && (m_el + 1 >= dur[m_ph]) && (m_ph != 0 || c || m_pend);
      if (adv) begin
        nph = (m_ph + 1) % 6;
        if (nph == 3) begin
          m_walk = m_pend;
          m_pend = 0;
        end else begin
          m_walk = 0;
        end
        m_ph = nph;
        m_el = 0;
      end else if (t) begin
        m_el++;
      end
      if (p) m_pend = 1;
    end
    #1;
    chk("main_light", 8'(main_light), 8'(exp_main(m_ph)));
    chk("side_light", 8'(side_light), 8'(exp_side(m_ph)));
    chk("walk", 8'(walk), 8'(m_walk));
    chk("phase", 8'(phase), 8'(m_ph));
    chk("one_road_red", 8'((main_light == 3'b100) || (side_light == 3'b100)), 8'd1);
  endtask

  // One second: three idle clocks then the tick clock
  task automatic tick1(input bit c, input bit p);
    repeat (3) cyc(1'b0, c, p, 1'b0);
    cyc(1'b1, c, p, 1'b0);
    if (walk === 1'b1) wt++;
    if (side_light !== 3'b100) sg++;
  endtask

  initial begin
    // Reset and startup
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_phase", 8'(phase), 8'd5);
    chk("rst_main", 8'(main_light), 8'h4);
    tick1(1'b0, 1'b0);
    chk("start_mg", 8'(main_light), 8'h1);
    wt = 0; sg = 0;
    repeat (45) tick1(1'b0, 1'b0);
    chk("mg_hold", 8'(main_light), 8'h1);
    chk("idle_walk", 8'(wt), 8'd0);
    chk("idle_side", 8'(sg), 8'd0);

    // Side-car demand from tick 2 of main green
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    tick1(1'b0, 1'b0);
    tick1(1'b0, 1'b0);
    n = 1; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick1(1'b1, 1'b0);
      n++;
      if (main_light === 3'b010) found = 1;
    end
    chk("car_to_yellow", 8'(n), 8'd10);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick1(1'b0, 1'b0);
      n++;
      if (main_light === 3'b001) found = 1;
    end
    chk("full_cycle", 8'(n), 8'd24);

    // Single pedestrian press
    repeat (12) tick1(1'b0, 1'b0);
    wt = 0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (30) tick1(1'b0, 1'b0);
    chk("ped_walk_len", 8'(wt), 8'd6);
    sg = 0;
    repeat (30) tick1(1'b0, 1'b0);
    chk("ped_cleared", 8'(sg), 8'd0);

    // Second press during side green gives one more walk cycle
    wt = 0; found = 0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30 && !found; i++) begin
      tick1(1'b0, 1'b0);
      if (side_light === 3'b001) found = 1;
    end
    chk("reach_sg", 8'(found), 8'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (40) tick1(1'b0, 1'b0);
    chk("ped_twice", 8'(wt), 8'd12);

    // Press on the very edge that enters side green
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick1(1'b0, 1'b0);
      if (m_ph == 2) found = 1;
    end
    chk("reach_ara", 8'(found), 8'd1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("coincide_walk", 8'(walk), 8'd1);
    chk("coincide_phase", 8'(phase), 8'd3);
    wt = 0;
    repeat (40) tick1(1'b0, 1'b0);
    chk("coincide_again", 8'(wt), 8'd11);

    // Reset at tick 4 of side green with a request pending
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick1(1'b0, 1'b0);
      if (m_ph == 3) found = 1;
    end
    chk("reach_sg2", 8'(found), 8'd1);
    repeat (3) tick1(1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("midrst_main", 8'(main_light), 8'h4);
    chk("midrst_side", 8'(side_light), 8'h4);
    chk("midrst_walk", 8'(walk), 8'd0);
    chk("midrst_phase", 8'(phase), 8'd5);
    sg = 0;
    repeat (31) tick1(1'b0, 1'b0);
    chk("midrst_discard", 8'(sg), 8'd0);

    // Tick gating in main yellow
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick1(1'b1, 1'b0);
      if (m_ph == 1) found = 1;
    end
    chk("reach_my", 8'(found), 8'd1);
    repeat (100) cyc(1'b0, $urandom_range(1) == 1, 1'b0, 1'b0);
    chk("gate_phase", 8'(phase), 8'd1);
    chk("gate_main", 8'(main_light), 8'h2);

    // Random traffic against the reference
    repeat (3000)
      cyc($urandom_range(2) == 0, $urandom_range(1) == 1,
          $urandom_range(19) == 0, $urandom_range(199) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
